booth16_seq_mult: RTL and testbench

Sequential radix-16 Booth multiplier controller and accumulator: the consumer end of the radix-16 Booth partial-product encoder. It latches operands and drives the encoder one 5-bit multiplier window per cycle. It takes back each `LENGTH+4`-bit partial product, then shifts and accumulates them into a `2*LENGTH`-bit product. It sits between a requesting datapath (start/done handshake) and one combinational encoder instance.

---
 rtl/booth16_seq_mult.sv | 128 ++++++++++++
 tb/tb_booth16_seq_mult.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth16_seq_mult.sv
// Sequential radix-16 Booth multiplier controller/accumulator.
// Drives an external combinational encoder one 5-bit multiplier window per
// cycle and shift-accumulates the returned partial products into the product.
module booth16_seq_mult #(
  parameter int unsigned LENGTH = 32,
  parameter bit          SIGNED = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [LENGTH-1:0]     a_i,
  input  logic [LENGTH-1:0]     b_i,
  output logic                  busy_o,
  output logic [LENGTH-1:0]     a_o,
  output logic [4:0]            b_sel_o,
  input  logic [LENGTH+3:0]     pp_i,
  output logic                  done_o,
  output logic [2*LENGTH-1:0]   product_o
);

  // Unsigned operands need one extra window to cover the zero-extended top bit.
  localparam int unsigned N  = SIGNED ? (LENGTH / 4) : (LENGTH / 4 + 1);
  localparam int unsigned CW = $clog2(N);
  localparam int unsigned PW = LENGTH + 4;
  localparam int unsigned AW = 2 * LENGTH + 4;
  localparam int unsigned BW = LENGTH + 5;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic                w_step;
  logic                w_last;
  logic                w_ext_in;

  logic [CW-1:0]       r_cnt;
  logic [BW-1:0]       r_bsh;
  logic [AW-1:0]       r_acc;
  logic [LENGTH-1:0]   r_a;
  logic [2*LENGTH-1:0] r_product;
  logic                r_done;

  logic [AW-1:0]       w_pp_ext;
  logic [AW-1:0]       w_term;
  logic [AW-1:0]       w_acc_sum;

  // Extension bit for the multiplier: sign in signed mode, zero otherwise.
  assign w_ext_in = SIGNED ? b_i[LENGTH-1] : 1'b0;

  // Partial product is always sign-extended, then weighted by 16^cnt.
  assign w_pp_ext  = {{LENGTH{pp_i[PW-1]}}, pp_i};
  assign w_term    = w_pp_ext << {r_cnt, 2'b00};
  assign w_acc_sum = r_acc + w_term;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and datapath control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_cnt == LAST) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand latch, window shifter, accumulator and result register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_a       <= '0;
      r_bsh     <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a   <= a_i;
        r_bsh <= {{4{w_ext_in}}, b_i, 1'b0};
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_step) begin
        r_acc <= w_acc_sum;
        r_cnt <= r_cnt + CW'(1);
        // The top bit of the shifter already holds the extension bit.
        r_bsh <= {{4{r_bsh[BW-1]}}, r_bsh[BW-1:4]};
        if (w_last) begin
          r_product <= w_acc_sum[2*LENGTH-1:0];
          r_done    <= 1'b1;
        end
      end
    end
  end

  assign busy_o    = (r_state == S_RUN);
  assign a_o       = r_a;
  assign b_sel_o   = r_bsh[4:0];
  assign done_o    = r_done;
  assign product_o = r_product;

endmodule

// File: tb/tb_booth16_seq_mult.sv
// Bench for booth16_seq_mult: a signed and an unsigned instance share one
// stimulus stream, each fed by a behavioural radix-16 Booth encoder.
module tb_booth16_seq_mult;

  logic        clk_i   = 1'b0;
  logic        rst_i   = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] a_i     = '0;
  logic [31:0] b_i     = '0;

  logic        busy [2];
  logic        done [2];
  logic [31:0] ao   [2];
  logic [4:0]  bsel [2];
  logic [35:0] pp   [2];
  logic [63:0] prod [2];

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned NW [2] = '{8, 9};

  always #5 clk_i = ~clk_i;

  booth16_seq_mult #(.LENGTH(32), .SIGNED(1'b1)) u_s (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .a_i(a_i), .b_i(b_i),
    .busy_o(busy[0]), .a_o(ao[0]), .b_sel_o(bsel[0]), .pp_i(pp[0]),
    .done_o(done[0]), .product_o(prod[0])
  );

  booth16_seq_mult #(.LENGTH(32), .SIGNED(1'b0)) u_u (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .a_i(a_i), .b_i(b_i),
    .busy_o(busy[1]), .a_o(ao[1]), .b_sel_o(bsel[1]), .pp_i(pp[1]),
    .done_o(done[1]), .product_o(prod[1])
  );

  // Booth digit = -8*w4 + 4*w3 + 2*w2 + w1 + w0, times the multiplicand.
  function automatic logic [35:0] enc(input logic [31:0] a, input logic [4:0] w, input bit sg);
    longint av;
    longint p;
    int     d;
    av = sg ? longint'($signed(a)) : longint'({32'b0, a});
    d  = -8 * int'(w[4]) + 4 * int'(w[3]) + 2 * int'(w[2]) + int'(w[1]) + int'(w[0]);
    p  = av * longint'(d);
    return p[35:0];
  endfunction

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit sg);
    if (sg) return 64'(longint'($signed(a)) * longint'($signed(b)));
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [4:0] win(input logic [31:0] b, input bit sg, input int unsigned j);
    logic [71:0] bx;
    bx = {{39{sg & b[31]}}, b, 1'b0};
    return 5'(bx >> (4 * j));
  endfunction

  assign pp[0] = enc(ao[0], bsel[0], 1'b1);
  assign pp[1] = enc(ao[1], bsel[1], 1'b0);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: remaining RUN cycles, pending result, visible outputs.
  int unsigned m_cnt  [2] = '{0, 0};
  logic        m_done [2] = '{1'b0, 1'b0};
  logic [63:0] m_prod [2] = '{64'd0, 64'd0};
  logic [63:0] m_pend [2] = '{64'd0, 64'd0};
  logic [31:0] m_a    [2] = '{32'd0, 32'd0};
  logic [31:0] m_b    [2] = '{32'd0, 32'd0};

  always @(posedge clk_i or posedge rst_i) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_i) begin
        m_cnt[k]  = 0;
        m_done[k] = 1'b0;
        m_prod[k] = '0;
        m_a[k]    = '0;
        m_b[k]    = '0;
      end else begin
        m_done[k] = 1'b0;
        if (m_cnt[k] == 0) begin
          if (start_i) begin
            m_cnt[k]  = NW[k];
            m_a[k]    = a_i;
            m_b[k]    = b_i;
            m_pend[k] = ref_mul(a_i, b_i, k == 0);
          end
        end else begin
          m_cnt[k] = m_cnt[k] - 1;
          if (m_cnt[k] == 0) begin
            m_done[k] = 1'b1;
            m_prod[k] = m_pend[k];
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk_i) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("busy%0d", k), 64'(busy[k]), 64'(m_cnt[k] != 0));
      chk($sformatf("done%0d", k), 64'(done[k]), 64'(m_done[k]));
      chk($sformatf("product%0d", k), prod[k], m_prod[k]);
      chk($sformatf("a_o%0d", k), 64'(ao[k]), 64'(m_a[k]));
      if (m_cnt[k] != 0)
        chk($sformatf("b_sel%0d", k), 64'(bsel[k]), 64'(win(m_b[k], k == 0, NW[k] - m_cnt[k])));
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] es, input logic [63:0] eu, input int poke);
    int nb [2];
    int nd [2];
    nb = '{0, 0};
    nd = '{0, 0};
    @(posedge clk_i); #1;
    start_i = 1'b1; a_i = a; b_i = b;
    @(posedge clk_i); #1;
    start_i = 1'b0; a_i = $urandom; b_i = $urandom;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk_i);
      for (int k = 0; k < 2; k++) begin
        if (busy[k]) nb[k]++;
        if (done[k]) nd[k]++;
      end
      if (j == poke) begin
        #1; start_i = 1'b1; a_i = 32'h0000_0055; b_i = 32'h0000_0066;
      end else if (j == poke + 1) begin
        #1; start_i = 1'b0;
      end
    end
    chk("op_busy_cycles_s", 64'(nb[0]), 64'd8);
    chk("op_busy_cycles_u", 64'(nb[1]), 64'd9);
    chk("op_done_pulses_s", 64'(nd[0]), 64'd1);
    chk("op_done_pulses_u", 64'(nd[1]), 64'd1);
    chk("op_product_s", prod[0], es);
    chk("op_product_u", prod[1], eu);
  endtask

  task automatic back_to_back();
    int          d1 [2];
    int          d2 [2];
    logic [63:0] p1 [2];
    logic [63:0] p2 [2];
    d1 = '{0, 0};
    d2 = '{0, 0};
    p1 = '{64'd0, 64'd0};
    p2 = '{64'd0, 64'd0};
    @(posedge clk_i); #1;
    start_i = 1'b1; a_i = 32'd3; b_i = 32'd5;
    @(posedge clk_i); #1;
    a_i = 32'hFFFF_FFF9; b_i = 32'd9;
    for (int j = 1; j <= 24; j++) begin
      @(negedge clk_i);
      for (int k = 0; k < 2; k++) begin
        if (done[k]) begin
          if (d1[k] == 0) begin d1[k] = j; p1[k] = prod[k]; end
          else if (d2[k] == 0) begin d2[k] = j; p2[k] = prod[k]; end
        end
      end
      if (j == 11) begin
        #1; start_i = 1'b0;
      end
    end
    chk("b2b_gap_s", 64'(d2[0] - d1[0]), 64'd9);
    chk("b2b_gap_u", 64'(d2[1] - d1[1]), 64'd10);
    chk("b2b_first_s", p1[0], 64'h0000_0000_0000_000F);
    chk("b2b_second_s", p2[0], 64'hFFFF_FFFF_FFFF_FFC1);
    chk("b2b_first_u", p1[1], 64'h0000_0000_0000_000F);
    chk("b2b_second_u", p2[1], 64'h0000_0008_FFFF_FFC1);
  endtask

  task automatic reset_mid_run();
    int dc;
    int bc;
    dc = 0;
    bc = 0;
    @(posedge clk_i); #1;
    start_i = 1'b1; a_i = 32'h1234_5678; b_i = 32'h9ABC_DEF0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (4) @(negedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_busy%0d", k), 64'(busy[k]), 64'd0);
      chk($sformatf("rst_done%0d", k), 64'(done[k]), 64'd0);
      chk($sformatf("rst_product%0d", k), prod[k], 64'd0);
      chk($sformatf("rst_a_o%0d", k), 64'(ao[k]), 64'd0);
      chk($sformatf("rst_b_sel%0d", k), 64'(bsel[k]), 64'd0);
    end
    repeat (3) begin
      @(negedge clk_i);
      dc += int'(done[0]) + int'(done[1]);
    end
    #1 rst_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      dc += int'(done[0]) + int'(done[1]);
      bc += int'(busy[0]) + int'(busy[1]);
    end
    chk("rst_no_done", 64'(dc), 64'd0);
    chk("rst_stays_idle", 64'(bc), 64'd0);
    run_op(32'hFFFF_FFF9, 32'd9, 64'hFFFF_FFFF_FFFF_FFC1, 64'h0000_0008_FFFF_FFC1, 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("init_busy%0d", k), 64'(busy[k]), 64'd0);
      chk($sformatf("init_done%0d", k), 64'(done[k]), 64'd0);
      chk($sformatf("init_product%0d", k), prod[k], 64'd0);
      chk($sformatf("init_b_sel%0d", k), 64'(bsel[k]), 64'd0);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);

    run_op(32'd3, 32'd5, 64'h0000_0000_0000_000F, 64'h0000_0000_0000_000F, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 64'hFFFF_FFFE_0000_0001, 0);
    run_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 0);
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0001, 64'h7FFF_FFFE_8000_0001, 0);
    run_op(32'd1234, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_F65C, 64'h0000_04D1_FFFF_F65C, 3);
    back_to_back();
    reset_mid_run();

    for (int c = 0; c < 400; c++) begin
      @(posedge clk_i); #1;
      start_i = ($urandom_range(0, 2) != 0);
      a_i     = pick();
      b_i     = pick();
    end
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (12) @(posedge clk_i);
    @(negedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
